apb_mem_bridge: RTL

APB_MEM_BRIDGE -- requirements
Module: apb_mem_bridge

---
 rtl/apb_mem_bridge.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/apb_mem_bridge.sv
// APB slave to single-port synchronous memory bridge.
// Each APB transfer becomes at most one memory access, which is aborted after TIMEOUT REQ cycles.
module apb_mem_bridge #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic                mem_cs_q, mem_cs_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_be_q, mem_be_d;
    logic                busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        prdata_d    = prdata_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        mem_cs_d    = mem_cs_q;
        mem_we_d    = mem_we_q;
        mem_re_d    = mem_re_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (psel && penable && !pready_q) begin
                    wr_d = pwrite;
                    if (32'(paddr) >= MEM_DEPTH) begin
                        // Out-of-range: answer with an error, memory untouched
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        if (!pwrite) begin
                            prdata_d = '0;
                        end
                    end else if (pwrite && (pstrb == '0)) begin
                        state_d  = S_RESP;
                        pready_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        mem_cs_d    = 1'b1;
                        mem_we_d    = pwrite;
                        mem_re_d    = !pwrite;
                        mem_addr_d  = paddr;
                        mem_wdata_d = pwdata;
                        mem_be_d    = pwrite ? pstrb : '1;
                    end
                end
            end
            S_REQ: begin
                // Completion takes priority over the timeout on the last cycle
                if (mem_ready) begin
                    state_d  = S_RESP;
                    pready_d = 1'b1;
                    mem_cs_d = 1'b0;
                    mem_we_d = 1'b0;
                    mem_re_d = 1'b0;
                    if (!wr_q) begin
                        prdata_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    mem_cs_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_re_d  = 1'b0;
                    if (!wr_q) begin
                        prdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign prdata    = prdata_q;
    assign pready    = pready_q;
    assign pslverr   = pslverr_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = busy_q;

endmodule
